// File: rtl/control_unit_seq_if.sv
// control_unit_seq_if: host instruction channel (word, valid, ready) into the sequenced control unit.
interface control_unit_seq_if #(parameter int INSTR_W = 96);
  logic [INSTR_W-1:0] instr_in;
  logic instr_valid_in;
  logic instr_ready_out;
  modport master (output instr_in, instr_valid_in, input instr_ready_out);
  modport slave (input instr_in, instr_valid_in, output instr_ready_out);
endinterface

// File: rtl/control_unit_seq.sv
// control_unit_seq: FIFO-buffered instruction sequencer issuing one word per slot with registered decoded fields and per-word hold.
// CTRL_UNIT_PARITY_EN adds even-parity checking: bad words are accepted, dropped, and flag a sticky error.
module control_unit_seq #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 16,
  parameter int ROW_W = 8,
  parameter int HOLD_W = 8
) (
  input  logic clk,
  input  logic rst,
  control_unit_seq_if.slave bus,
  input  logic stall_in,
`ifdef CTRL_UNIT_PARITY_EN
  input  logic instr_parity_in,
  output logic parity_err_out,
`endif
  output logic issue_valid_out,
  output logic busy_out,
  output logic sys_switch_in,
  output logic ub_rd_start_in,
  output logic ub_rd_transpose,
  output logic ub_wr_host_valid_in_1,
  output logic ub_wr_host_valid_in_2,
  output logic [1:0] ub_rd_col_size,
  output logic [ROW_W-1:0] ub_rd_row_size,
  output logic [1:0] ub_rd_addr_in,
  output logic [2:0] ub_ptr_sel,
  output logic [DATA_W-1:0] ub_wr_host_data_in_1,
  output logic [DATA_W-1:0] ub_wr_host_data_in_2,
  output logic [3:0] vpu_data_pathway,
  output logic [DATA_W-1:0] inv_batch_size_times_two_in,
  output logic [DATA_W-1:0] vpu_leak_factor_in
);
  localparam int INSTR_W = 16 + ROW_W + 4 * DATA_W + HOLD_W;
  localparam int AW = $clog2(DEPTH);
  localparam int LVL_W = INSTR_W - HOLD_W - 5;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t r_state;
  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic [HOLD_W-1:0] r_cnt;
  logic [4:0] r_strobe;
  logic [LVL_W-1:0] r_level;
  logic r_issue;
  logic [INSTR_W-1:0] w_head;
  logic w_full, w_empty, w_accept, w_push, w_free, w_pop;
  assign w_full = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}};
  assign w_empty = r_wr_ptr == r_rd_ptr;
  assign bus.instr_ready_out = rst && !w_full;
  assign w_accept = bus.instr_valid_in && bus.instr_ready_out;
`ifdef CTRL_UNIT_PARITY_EN
  logic r_par_err;
  assign w_push = w_accept && (instr_parity_in == ^bus.instr_in);
  assign parity_err_out = r_par_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_par_err <= 1'b0;
    else if (w_accept && !w_push) r_par_err <= 1'b1;
  end
`else
  assign w_push = w_accept;
`endif
  assign w_head = r_mem[r_rd_ptr[AW-1:0]];
  // The slot frees in the last output cycle of the current word so the next one issues right after it.
  assign w_free = (r_state == IDLE) || (r_state == ISSUE && r_cnt == '0) || (r_state == HOLD && r_cnt == HOLD_W'(1));
  assign w_pop = w_free && !w_empty && !stall_in;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.instr_in;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt <= '0;
      r_strobe <= '0;
      r_level <= '0;
      r_issue <= 1'b0;
    end else begin
      r_issue <= w_pop;
      r_strobe <= w_pop ? w_head[4:0] : 5'd0;
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        r_level <= w_head[5 +: LVL_W];
        r_cnt <= w_head[INSTR_W-1 -: HOLD_W];
        r_state <= ISSUE;
      end else if (w_free) r_state <= IDLE;
      else if (r_state == ISSUE) r_state <= HOLD;
      else r_cnt <= r_cnt - HOLD_W'(1);
    end
  end
  assign issue_valid_out = r_issue;
  assign busy_out = !w_empty || r_state != IDLE;
  assign {ub_wr_host_valid_in_2, ub_wr_host_valid_in_1, ub_rd_transpose, ub_rd_start_in, sys_switch_in} = r_strobe;
  assign ub_rd_col_size = r_level[1:0];
  assign ub_rd_row_size = r_level[2 +: ROW_W];
  assign ub_rd_addr_in = r_level[2+ROW_W +: 2];
  assign ub_ptr_sel = r_level[4+ROW_W +: 3];
  assign ub_wr_host_data_in_1 = r_level[7+ROW_W +: DATA_W];
  assign ub_wr_host_data_in_2 = r_level[7+ROW_W+DATA_W +: DATA_W];
  assign vpu_data_pathway = r_level[7+ROW_W+2*DATA_W +: 4];
  assign inv_batch_size_times_two_in = r_level[11+ROW_W+2*DATA_W +: DATA_W];
  assign vpu_leak_factor_in = r_level[11+ROW_W+3*DATA_W +: DATA_W];
endmodule

// File: tb/tb_control_unit_seq.sv
// tb_control_unit_seq: scoreboard bench; accepted words are queued as expected issues and checked when the DUT issues them.
`timescale 1ns/1ps
module tb_control_unit_seq;
  localparam int DEPTH = 4, DATA_W = 16, ROW_W = 8, HOLD_W = 8;
  localparam int IW = 16 + ROW_W + 4 * DATA_W + HOLD_W;
  localparam int LW = IW - HOLD_W - 5;
  logic clk = 1'b0, rst = 1'b0, stall_in = 1'b0;
  logic issue_valid_out, busy_out, sys_switch_in, ub_rd_start_in, ub_rd_transpose;
  logic ub_wr_host_valid_in_1, ub_wr_host_valid_in_2;
  logic [1:0] ub_rd_col_size, ub_rd_addr_in;
  logic [ROW_W-1:0] ub_rd_row_size;
  logic [2:0] ub_ptr_sel;
  logic [DATA_W-1:0] ub_wr_host_data_in_1, ub_wr_host_data_in_2, inv_batch_size_times_two_in, vpu_leak_factor_in;
  logic [3:0] vpu_data_pathway;
`ifdef CTRL_UNIT_PARITY_EN
  logic instr_parity_in = 1'b0;
  logic parity_err_out;
`endif
  control_unit_seq_if #(.INSTR_W(IW)) bus ();
  control_unit_seq #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ROW_W(ROW_W), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_in(stall_in),
`ifdef CTRL_UNIT_PARITY_EN
    .instr_parity_in(instr_parity_in), .parity_err_out(parity_err_out),
`endif
    .issue_valid_out(issue_valid_out), .busy_out(busy_out), .sys_switch_in(sys_switch_in),
    .ub_rd_start_in(ub_rd_start_in), .ub_rd_transpose(ub_rd_transpose),
    .ub_wr_host_valid_in_1(ub_wr_host_valid_in_1), .ub_wr_host_valid_in_2(ub_wr_host_valid_in_2),
    .ub_rd_col_size(ub_rd_col_size), .ub_rd_row_size(ub_rd_row_size), .ub_rd_addr_in(ub_rd_addr_in),
    .ub_ptr_sel(ub_ptr_sel), .ub_wr_host_data_in_1(ub_wr_host_data_in_1), .ub_wr_host_data_in_2(ub_wr_host_data_in_2),
    .vpu_data_pathway(vpu_data_pathway), .inv_batch_size_times_two_in(inv_batch_size_times_two_in),
    .vpu_leak_factor_in(vpu_leak_factor_in)
  );
  wire [IW-HOLD_W-1:0] w_act = {vpu_leak_factor_in, inv_batch_size_times_two_in, vpu_data_pathway,
    ub_wr_host_data_in_2, ub_wr_host_data_in_1, ub_ptr_sel, ub_rd_addr_in, ub_rd_row_size, ub_rd_col_size,
    ub_wr_host_valid_in_2, ub_wr_host_valid_in_1, ub_rd_transpose, ub_rd_start_in, sys_switch_in};
  logic [IW-1:0] exp_q[$];
  int iss_q[$];
  logic [IW-1:0] m_exp;
  logic [LW-1:0] lvl_exp = '0;
  int n_tests = 0, n_fail = 0, cyc = 0, push_cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst) lvl_exp = '0;
    n_tests++;
    if (issue_valid_out) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got issue act=%h, required no issue", w_act);
      end else begin
        m_exp = exp_q.pop_front();
        iss_q.push_back(cyc);
        lvl_exp = m_exp[5 +: LW];
        if (w_act !== m_exp[IW-HOLD_W-1:0]) begin
          n_fail++;
          $display("FAIL issue_fields: got %h, required %h", w_act, m_exp[IW-HOLD_W-1:0]);
        end
      end
    end else if (w_act !== {lvl_exp, 5'b0}) begin
      n_fail++;
      $display("FAIL idle_fields: got %h, required %h", w_act, {lvl_exp, 5'b0});
    end
  end
  function automatic logic [IW-1:0] mk(input logic [4:0] s, input logic [ROW_W-1:0] row, input logic [HOLD_W-1:0] hold);
    return {hold, DATA_W'($urandom), DATA_W'($urandom), 4'($urandom), DATA_W'($urandom), DATA_W'($urandom),
            3'($urandom), 2'($urandom), row, 2'($urandom), s};
  endfunction
  task automatic push(input logic [IW-1:0] w, input logic good);
    int t = 0;
    @(negedge clk);
    bus.instr_in = w;
    bus.instr_valid_in = 1'b1;
`ifdef CTRL_UNIT_PARITY_EN
    instr_parity_in = good ? ^w : ~^w;
`endif
    while (!bus.instr_ready_out && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t == 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: ready stayed %b, required 1", bus.instr_ready_out);
    end else begin
      @(posedge clk);
      if (good) exp_q.push_back(w);
      #1 push_cyc = cyc;
    end
    bus.instr_valid_in = 1'b0;
  endtask
  task automatic wait_issues(input int n, input string name);
    int t = 0;
    while (iss_q.size() < n && t < 200) begin
      @(negedge clk);
      #1 t++;
    end
    n_tests++;
    if (iss_q.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: issues %0d, required %0d", name, iss_q.size(), n);
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1 n_tests++;
    if ({issue_valid_out, busy_out, w_act} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b/%b/%h, required all 0", issue_valid_out, busy_out, w_act);
    end
    @(negedge clk) rst = 1'b1;
    #1 n_tests++;
    if (bus.instr_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 1", bus.instr_ready_out);
    end
  endtask
  task automatic test_single;
    int base;
    iss_q.delete();
    push(mk(5'b00011, 8'd4, 8'd0), 1'b1);
    base = push_cyc;
    wait_issues(1, "single");
    n_tests++;
    if (iss_q.size() != 1 || iss_q[0] != base + 1 || {issue_valid_out, sys_switch_in, ub_rd_start_in, ub_rd_transpose} !== 4'b1110) begin
      n_fail++;
      $display("FAIL single_issue: cycle %0d strobes %b, required cycle %0d strobes 1110", iss_q.size() ? iss_q[0] : -1,
               {issue_valid_out, sys_switch_in, ub_rd_start_in, ub_rd_transpose}, base + 1);
    end
    @(negedge clk);
    #1 n_tests++;
    if ({issue_valid_out, sys_switch_in, ub_rd_start_in, ub_rd_row_size} !== {3'b000, 8'd4}) begin
      n_fail++;
      $display("FAIL single_after: got %b row %0d, required 000 row 4", {issue_valid_out, sys_switch_in, ub_rd_start_in}, ub_rd_row_size);
    end
  endtask
  task automatic test_hold_b2b;
    iss_q.delete();
    push(mk(5'b11111, 8'd9, 8'd3), 1'b1);
    push(mk(5'b10101, 8'd17, 8'd0), 1'b1);
    wait_issues(1, "b2b_first");
    @(negedge clk);
    #1 n_tests++;
    if ({busy_out, issue_valid_out, sys_switch_in, ub_wr_host_valid_in_2, ub_rd_row_size} !== {4'b1000, 8'd9}) begin
      n_fail++;
      $display("FAIL b2b_hold_cycle: got %b row %0d, required 1000 row 9",
               {busy_out, issue_valid_out, sys_switch_in, ub_wr_host_valid_in_2}, ub_rd_row_size);
    end
    wait_issues(2, "b2b_second");
    n_tests++;
    if (iss_q.size() != 2 || iss_q[1] - iss_q[0] != 4) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles, required 4", iss_q.size() == 2 ? iss_q[1] - iss_q[0] : -1);
    end
    repeat (3) @(negedge clk);
    #1 n_tests++;
    if (busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain_busy: got %b, required 0", busy_out);
    end
  endtask
  task automatic test_fill;
    iss_q.delete();
    stall_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(mk(5'(i + 1), 8'(i + 20), 8'd0), 1'b1);
    @(negedge clk);
    #1 n_tests++;
    if ({bus.instr_ready_out, busy_out} !== 2'b01 || iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL fill_full: ready %b busy %b issues %0d, required ready 0 busy 1 issues 0",
               bus.instr_ready_out, busy_out, iss_q.size());
    end
    fork
      push(mk(5'b11000, 8'd99, 8'd0), 1'b1);
      begin
        repeat (3) @(negedge clk);
        stall_in = 1'b0;
      end
    join
    wait_issues(DEPTH + 1, "fill");
    n_tests++;
    if (iss_q.size() != DEPTH + 1 || iss_q[DEPTH] - iss_q[0] != DEPTH || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fill_drain: issues %0d left %0d, required %0d consecutive issues and 0 left", iss_q.size(), exp_q.size(), DEPTH + 1);
    end
  endtask
  task automatic test_stall_hold;
    iss_q.delete();
    push(mk(5'b00001, 8'd3, 8'd4), 1'b1);
    push(mk(5'b00010, 8'd5, 8'd0), 1'b1);
    wait_issues(1, "stall_short_first");
    stall_in = 1'b1;
    repeat (2) @(negedge clk);
    stall_in = 1'b0;
    wait_issues(2, "stall_short_second");
    n_tests++;
    if (iss_q.size() != 2 || iss_q[1] - iss_q[0] != 5) begin
      n_fail++;
      $display("FAIL stall_short_spacing: got %0d, required 5", iss_q.size() == 2 ? iss_q[1] - iss_q[0] : -1);
    end
    iss_q.delete();
    push(mk(5'b00100, 8'd6, 8'd2), 1'b1);
    push(mk(5'b01000, 8'd7, 8'd0), 1'b1);
    wait_issues(1, "stall_long_first");
    stall_in = 1'b1;
    repeat (6) @(negedge clk);
    #1 n_tests++;
    if (iss_q.size() != 1 || busy_out !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_long_blocked: issues %0d busy %b, required 1 issue busy 1", iss_q.size(), busy_out);
    end
    stall_in = 1'b0;
    wait_issues(2, "stall_long_second");
    n_tests++;
    if (iss_q.size() != 2 || iss_q[1] - iss_q[0] != 7) begin
      n_fail++;
      $display("FAIL stall_long_spacing: got %0d, required 7", iss_q.size() == 2 ? iss_q[1] - iss_q[0] : -1);
    end
  endtask
  task automatic test_reset_mid;
    iss_q.delete();
    push(mk(5'b11111, 8'd40, 8'd6), 1'b1);
    push(mk(5'b00001, 8'd41, 8'd0), 1'b1);
    push(mk(5'b00010, 8'd42, 8'd0), 1'b1);
    wait_issues(1, "rst_mid_first");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    #1 n_tests++;
    if ({issue_valid_out, busy_out, w_act} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b/%b/%h, required all 0", issue_valid_out, busy_out, w_act);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 n_tests++;
    if (bus.instr_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_ready: got %b, required 1", bus.instr_ready_out);
    end
    repeat (10) @(negedge clk);
    #1 n_tests++;
    if (iss_q.size() != 1 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_discard: issues %0d busy %b, required 1 issue busy 0", iss_q.size(), busy_out);
    end
  endtask
`ifdef CTRL_UNIT_PARITY_EN
  task automatic test_parity;
    iss_q.delete();
    push(mk(5'b00001, 8'd50, 8'd0), 1'b1);
    n_tests++;
    if (parity_err_out !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_clean: got %b, required 0", parity_err_out);
    end
    push(mk(5'b00010, 8'd51, 8'd0), 1'b0);
    push(mk(5'b00100, 8'd52, 8'd0), 1'b1);
    wait_issues(2, "parity");
    repeat (6) @(negedge clk);
    #1 n_tests++;
    if (iss_q.size() != 2 || parity_err_out !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL parity_drop: issues %0d err %b, required 2 issues err 1", iss_q.size(), parity_err_out);
    end
  endtask
`endif
  initial begin
    bus.instr_in = '0;
    bus.instr_valid_in = 1'b0;
    test_reset();
    test_single();
    test_hold_b2b();
    test_fill();
    test_stall_hold();
    test_reset_mid();
`ifdef CTRL_UNIT_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
